knn_vote: RTL and testbench

KNN_VOTE -- requirements
Module: knn_vote

---
 rtl/knn_vote.sv | 174 +++++++++++++++++
 tb/tb_knn_vote.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// k-nearest-neighbour vote: keeps the K closest candidates of each NUM_CAND-word sample
// sorted by distance, then picks the most frequent label (ties go to the smaller label).
module knn_vote #(
  parameter int unsigned NUM_CAND = 30,
  parameter int unsigned K        = 3
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [31:0] Input_1_V_V,
  input  logic        Input_1_V_V_ap_vld,
  output logic        Input_1_V_V_ap_ack,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack
);

  localparam logic [7:0] LastCnt = 8'(NUM_CAND - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StVote, StOutput} state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt;
  logic [K-1:0] r_slot_vld, w_slot_vld_d;
  logic [15:0] r_slot_dist [K];
  logic [15:0] w_slot_dist_d [K];
  logic [3:0]  r_slot_lbl [K];
  logic [3:0]  w_slot_lbl_d [K];
  logic [3:0]  r_vote_lbl, r_best_lbl, r_best_cnt;
  logic [31:0] r_out;

  logic        w_clear, w_xfer, w_last_vote, w_better;
  logic [15:0] w_cand_dist;
  logic [3:0]  w_cand_lbl, w_vote_cnt, w_fin_lbl, w_fin_cnt;
  logic        w_cand_ok;
  logic [K-1:0] w_ins, w_ins_prev;
  logic        w_unused;

  assign w_cand_dist = Input_1_V_V[23:8];
  assign w_cand_lbl  = Input_1_V_V[3:0];
  assign w_cand_ok   = (w_cand_lbl <= 4'd9);
  assign w_unused    = ^{Input_1_V_V[31:24], Input_1_V_V[7:4]};

  // Slot i takes the candidate at the first position where it ranks nearer; slots behind
  // that point shift down by one and whatever leaves slot K-1 is lost.
  always_comb begin
    w_ins         = '0;
    w_ins_prev    = '0;
    w_slot_vld_d  = r_slot_vld;
    w_slot_dist_d = r_slot_dist;
    w_slot_lbl_d  = r_slot_lbl;
    for (int i = 0; i < int'(K); i++) begin
      w_ins[i] = !r_slot_vld[i] || (w_cand_dist < r_slot_dist[i]);
    end
    for (int i = 1; i < int'(K); i++) begin
      w_ins_prev[i] = w_ins[i-1];
    end
    if (w_cand_ok) begin
      for (int i = 1; i < int'(K); i++) begin
        if (w_ins_prev[i]) begin
          w_slot_vld_d[i]  = r_slot_vld[i-1];
          w_slot_dist_d[i] = r_slot_dist[i-1];
          w_slot_lbl_d[i]  = r_slot_lbl[i-1];
        end
      end
      for (int i = 0; i < int'(K); i++) begin
        if (w_ins[i] && !w_ins_prev[i]) begin
          w_slot_vld_d[i]  = 1'b1;
          w_slot_dist_d[i] = w_cand_dist;
          w_slot_lbl_d[i]  = w_cand_lbl;
        end
      end
    end
  end

  always_comb begin
    w_vote_cnt = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (r_slot_vld[i] && (r_slot_lbl[i] == r_vote_lbl)) begin
        w_vote_cnt = w_vote_cnt + 4'd1;
      end
    end
    w_better    = (w_vote_cnt > r_best_cnt);
    w_fin_lbl   = w_better ? r_vote_lbl : r_best_lbl;
    w_fin_cnt   = w_better ? w_vote_cnt : r_best_cnt;
    w_last_vote = (r_vote_lbl == 4'd9);
  end

  always_comb begin
    w_state_d           = r_state;
    w_clear             = 1'b0;
    w_xfer              = 1'b0;
    ap_done             = 1'b0;
    ap_ready            = 1'b0;
    ap_idle             = 1'b0;
    Input_1_V_V_ap_ack  = 1'b0;
    Output_1_V_V_ap_vld = 1'b0;
    unique case (r_state)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          w_state_d = StCollect;
          w_clear   = 1'b1;
        end
      end
      StCollect: begin
        Input_1_V_V_ap_ack = Input_1_V_V_ap_vld;
        if (Input_1_V_V_ap_vld) begin
          w_xfer = 1'b1;
          if (r_cnt == LastCnt) w_state_d = StVote;
        end
      end
      StVote: begin
        if (w_last_vote) w_state_d = StOutput;
      end
      StOutput: begin
        Output_1_V_V_ap_vld = 1'b1;
        if (Output_1_V_V_ap_ack) begin
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          if (ap_start) begin
            w_state_d = StCollect;
            w_clear   = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign Output_1_V_V = r_out;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_slot_vld <= '0;
      for (int i = 0; i < int'(K); i++) begin
        r_slot_dist[i] <= '0;
        r_slot_lbl[i]  <= '0;
      end
      r_vote_lbl <= '0;
      r_best_lbl <= '0;
      r_best_cnt <= '0;
      r_out      <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_clear) begin
        r_cnt      <= '0;
        r_slot_vld <= '0;
        r_vote_lbl <= '0;
        // No label has scored yet: an all-invalid sample reports label F with zero votes
        r_best_lbl <= 4'hF;
        r_best_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt       <= r_cnt + 8'd1;
        r_slot_vld  <= w_slot_vld_d;
        r_slot_dist <= w_slot_dist_d;
        r_slot_lbl  <= w_slot_lbl_d;
      end else if (r_state == StVote) begin
        r_vote_lbl <= r_vote_lbl + 4'd1;
        r_best_lbl <= w_fin_lbl;
        r_best_cnt <= w_fin_cnt;
        if (w_last_vote) r_out <= {20'b0, w_fin_cnt, 4'b0, w_fin_lbl};
      end
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Randomized self-checking bench for knn_vote against a top-K stable-sort reference model.
module tb_knn_vote;
  localparam int NC = 30;
  localparam int KK = 3;

  typedef logic [31:0] wq_t[$];

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_idle, ap_ready;
  logic [31:0] in_data = '0;
  logic        in_vld = 1'b0;
  logic        in_ack;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  knn_vote #(.NUM_CAND(NC), .K(KK)) dut (
    .ap_clk             (ap_clk),
    .ap_rst_n           (ap_rst_n),
    .ap_start           (ap_start),
    .ap_done            (ap_done),
    .ap_idle            (ap_idle),
    .ap_ready           (ap_ready),
    .Input_1_V_V        (in_data),
    .Input_1_V_V_ap_vld (in_vld),
    .Input_1_V_V_ap_ack (in_ack),
    .Output_1_V_V       (out_data),
    .Output_1_V_V_ap_vld(out_vld),
    .Output_1_V_V_ap_ack(out_ack)
  );

  // Ignored bits are filled with noise.
  function automatic logic [31:0] mkw(input logic [15:0] d, input logic [3:0] l);
    logic [7:0] hi;
    logic [3:0] mid;
    hi  = 8'($urandom);
    mid = 4'($urandom);
    return {hi, d, mid, l};
  endfunction

  // Reference: pick the K nearest valid-label words, earliest arrival first among equal
  // distances, then the label with most votes (smallest label on ties).
  function automatic logic [31:0] model(input wq_t w);
    bit used[$];
    int cnt[10];
    int best_l = 15;
    int best_c = 0;
    int pick;
    foreach (w[i]) used.push_back(1'b0);
    for (int l = 0; l < 10; l++) cnt[l] = 0;
    for (int k = 0; k < KK; k++) begin
      pick = -1;
      foreach (w[i]) begin
        if (!used[i] && w[i][3:0] <= 4'd9 &&
            (pick < 0 || w[i][23:8] < w[pick][23:8])) pick = i;
      end
      if (pick >= 0) begin
        used[pick] = 1'b1;
        cnt[int'(w[pick][3:0])]++;
      end
    end
    for (int l = 0; l < 10; l++) begin
      if (cnt[l] > best_c) begin
        best_c = cnt[l];
        best_l = l;
      end
    end
    return {20'b0, 4'(best_c), 4'b0, 4'(best_l)};
  endfunction

  function automatic wq_t build_dir(input int which);
    wq_t w;
    for (int i = 0; i < NC; i++) begin
      case (which)
        0: w.push_back(mkw(16'h0100, 4'd1));
        1: w.push_back(mkw(16'h0100, 4'd0));
        2: w.push_back(mkw(16'h0100, 4'd8));
        default: w.push_back(mkw(16'($urandom), 4'hA));
      endcase
    end
    case (which)
      0: begin w[5] = mkw(16'h0010, 4'd7); w[17] = mkw(16'h0011, 4'd7); w[29] = mkw(16'h0012, 4'd2); end
      1: begin w[0] = mkw(16'h0010, 4'd5); w[10] = mkw(16'h0011, 4'd3); w[20] = mkw(16'h0012, 4'd9); end
      2: begin
        w[3] = mkw(16'h0020, 4'd6); w[4] = mkw(16'h0020, 4'd1);
        w[8] = mkw(16'h0020, 4'd1); w[12] = mkw(16'h0020, 4'd4);
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic wq_t build_rand();
    wq_t w;
    for (int i = 0; i < NC; i++) begin
      w.push_back(mkw(16'($urandom_range(0, 15)), 4'($urandom_range(0, 11))));
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    in_vld   = 1'b0;
    out_ack  = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic start_sample(output bit ok);
    ok = 1'b0;
    @(negedge ap_clk);
    ap_start = 1'b1;
    in_vld   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (ap_idle === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Feeds one sample, then waits for the result; lat counts negedge samples after the
  // last transfer edge until the result is seen valid.
  task automatic drive_sample(input wq_t w, input bit gaps, input bit drop_start,
                              output logic [31:0] res, output int lat, output int ack_bad,
                              output bit tmo);
    int  idx = 0;
    int  cyc = 0;
    bit  v;
    res = '0; lat = 0; ack_bad = 0; tmo = 1'b0;
    while (idx < w.size() && cyc < 2000) begin
      @(negedge ap_clk);
      cyc++;
      v       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_vld  = v;
      in_data = v ? w[idx] : $urandom;
      out_ack = 1'($urandom);
      #1;
      if (in_ack !== v) ack_bad++;
      if (v) begin
        idx++;
        if (drop_start) ap_start = 1'b0;
      end
    end
    if (idx < w.size()) tmo = 1'b1;
    else begin
      while (lat < 40) begin
        @(negedge ap_clk);
        lat++;
        out_ack = 1'b0;
        if (out_vld === 1'b1) break;
        in_vld  = 1'($urandom);
        in_data = $urandom;
        out_ack = 1'($urandom);
        #1;
        if (in_ack !== 1'b0) ack_bad++;
      end
      if (out_vld !== 1'b1) tmo = 1'b1;
    end
    in_vld  = 1'b0;
    out_ack = 1'b0;
    res     = out_data;
  endtask

  task automatic ack_output(input bit restart, output logic done_p, output logic ready_p,
                            output logic vld_after, output logic done_after,
                            output logic idle_after);
    @(negedge ap_clk);
    ap_start = restart;
    out_ack  = 1'b1;
    #1;
    done_p  = ap_done;
    ready_p = ap_ready;
    @(negedge ap_clk);
    out_ack = 1'b0;
    #1;
    vld_after  = out_vld;
    done_after = ap_done;
    idle_after = ap_idle;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 1'b1; in_vld = 1'b1; out_ack = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    n_tests += 6;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%b want=1", ap_idle); end
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h want=0", out_data); end
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_ovld got=%b want=0", out_vld); end
    if (in_ack !== 1'b0) begin n_fail++; $display("FAIL rst_iack got=%b want=0", in_ack); end
    if (ap_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b want=0", ap_done); end
    if (ap_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b want=0", ap_ready); end
    ap_start = 1'b0; in_vld = 1'b0; out_ack = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    n_tests++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL idle_no_start got=%b want=1", ap_idle); end
  endtask

  task automatic check_sample(input string name, input wq_t w, input logic [31:0] res,
                              input int lat, input int ack_bad, input bit tmo);
    logic [31:0] exp_res;
    exp_res = model(w);
    n_tests += 3;
    if (tmo || res !== exp_res) begin
      n_fail++; $display("FAIL %s_result got=%h want=%h timeout=%0b", name, res, exp_res, tmo);
    end
    if (lat != 11) begin n_fail++; $display("FAIL %s_latency got=%0d want=11", name, lat); end
    if (ack_bad != 0) begin n_fail++; $display("FAIL %s_ack got=%0d bad want=0", name, ack_bad); end
  endtask

  task automatic test_directed();
    logic [31:0] exp_c[4] = '{32'h0000_0207, 32'h0000_0103, 32'h0000_0201, 32'h0000_000F};
    wq_t w;
    logic [31:0] res;
    int lat, ack_bad;
    bit tmo, ok;
    logic dp, rp, va, da, ia;
    for (int t = 0; t < 4; t++) begin
      w = build_dir(t);
      start_sample(ok);
      drive_sample(w, 1'b0, 1'b0, res, lat, ack_bad, tmo);
      n_tests++;
      if (res !== exp_c[t]) begin n_fail++; $display("FAIL dir%0d_const got=%h want=%h", t, res, exp_c[t]); end
      check_sample($sformatf("dir%0d", t), w, res, lat, ack_bad, tmo);
      ack_output(1'b0, dp, rp, va, da, ia);
      n_tests++;
      if (dp !== 1'b1) begin n_fail++; $display("FAIL dir%0d_done got=%b want=1", t, dp); end
    end
  endtask

  task automatic test_random();
    wq_t w;
    logic [31:0] res;
    int lat, ack_bad;
    bit tmo, ok;
    logic dp, rp, va, da, ia;
    for (int t = 0; t < 8; t++) begin
      w = build_rand();
      start_sample(ok);
      drive_sample(w, 1'b1, 1'(t % 2), res, lat, ack_bad, tmo);
      check_sample($sformatf("rnd%0d", t), w, res, lat, ack_bad, tmo);
      ack_output(1'b0, dp, rp, va, da, ia);
      n_tests++;
      if (va !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_vld_drop got=%b want=0", t, va); end
    end
  endtask

  task automatic test_hold();
    wq_t w;
    logic [31:0] res;
    int lat, ack_bad, bad;
    bit tmo, ok;
    logic dp, rp, va, da, ia;
    w = build_rand();
    start_sample(ok);
    drive_sample(w, 1'b0, 1'b1, res, lat, ack_bad, tmo);
    check_sample("hold", w, res, lat, ack_bad, tmo);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      out_ack = 1'b0;
      if (out_vld !== 1'b1 || out_data !== res || ap_done !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL hold_stable got=%0d unstable cycles want=0", bad); end
    ack_output(1'b0, dp, rp, va, da, ia);
    n_tests += 5;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b want=1", dp); end
    if (rp !== 1'b1) begin n_fail++; $display("FAIL hold_ready got=%b want=1", rp); end
    if (va !== 1'b0) begin n_fail++; $display("FAIL hold_vld_after got=%b want=0", va); end
    if (da !== 1'b0) begin n_fail++; $display("FAIL hold_done_after got=%b want=0", da); end
    if (ia !== 1'b1) begin n_fail++; $display("FAIL hold_idle_after got=%b want=1", ia); end
  endtask

  task automatic test_back_to_back();
    wq_t w;
    logic [31:0] res;
    int lat, ack_bad;
    bit tmo, ok;
    logic dp, rp, va, da, ia;
    w = build_rand();
    start_sample(ok);
    drive_sample(w, 1'b1, 1'b0, res, lat, ack_bad, tmo);
    check_sample("b2b_a", w, res, lat, ack_bad, tmo);
    ack_output(1'b1, dp, rp, va, da, ia);
    n_tests += 3;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b want=1", dp); end
    if (va !== 1'b0) begin n_fail++; $display("FAIL b2b_vld_after got=%b want=0", va); end
    if (ia !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_idle got=%b want=0", ia); end
    w = build_rand();
    drive_sample(w, 1'b0, 1'b1, res, lat, ack_bad, tmo);
    check_sample("b2b_b", w, res, lat, ack_bad, tmo);
    ack_output(1'b0, dp, rp, va, da, ia);
  endtask

  task automatic test_midreset();
    wq_t w;
    logic [31:0] res;
    int lat, ack_bad, seen;
    bit tmo, ok;
    logic dp, rp, va, da, ia;
    start_sample(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mid_start got=%b want=1", ok); end
    ap_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ap_clk);
      in_vld  = 1'b1;
      in_data = mkw(16'($urandom_range(0, 3)), 4'($urandom_range(0, 9)));
    end
    do_reset();
    #1;
    n_tests++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle got=%b want=1", ap_idle); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (out_vld !== 1'b0 || ap_idle !== 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_no_output got=%0d bad cycles want=0", seen); end
    w = build_rand();
    start_sample(ok);
    drive_sample(w, 1'b1, 1'b1, res, lat, ack_bad, tmo);
    check_sample("mid_fresh", w, res, lat, ack_bad, tmo);
    // Pending result discarded by reset
    do_reset();
    #1;
    n_tests += 2;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL outrst_vld got=%b want=0", out_vld); end
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL outrst_data got=%h want=0", out_data); end
    w = build_rand();
    start_sample(ok);
    drive_sample(w, 1'b0, 1'b1, res, lat, ack_bad, tmo);
    check_sample("post_rst", w, res, lat, ack_bad, tmo);
    ack_output(1'b0, dp, rp, va, da, ia);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
